// File: rtl/sig_unrect.sv
// sig_unrect: re-applies stored raw sample signs to a rectified magnitude stream.
// Optional sticky saturation flag port enabled by SIG_UNRECT_SAT_FLAG_EN.
module sig_unrect #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       raw_valid,
   input  logic [8:0] raw_data,
   output logic       raw_ready,
   input  logic       mag_valid,
   input  logic [8:0] mag_data,
   output logic       mag_ready,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [8:0] result
`ifdef SIG_UNRECT_SAT_FLAG_EN
   ,
   output logic       sat_err
`endif
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] sgn_mem;
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;
   logic [CW-1:0]    count;
   logic             push;
   logic             pop;
   logic             sgn;
   logic [8:0]       restored;
   logic             unused_raw;

   assign unused_raw = ^raw_data[7:0];

   // handshakes: no pass-through at full, no bypass at empty
   assign raw_ready = (count != CW'(DEPTH));
   assign mag_ready = (count != '0) && (!out_valid || out_ready);
   assign push      = raw_valid && raw_ready;
   assign pop       = mag_valid && mag_ready;
   assign sgn       = sgn_mem[rptr];

   // rebuild signed sample; positive magnitudes above 255 clamp to +255
   always_comb begin
      restored = mag_data;
      if (sgn) begin
         restored = ~mag_data + 9'd1;
      end else if (mag_data[8]) begin
         restored = 9'h0FF;
      end
   end

   // sign storage, only the sign bit of each raw sample is kept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sgn_mem <= '0;
      end else if (push) begin
         sgn_mem[wptr] <= raw_data[8];
      end
   end

   // pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + PW'(1);
         if (pop)  rptr <= rptr + PW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // registered output stage with hold under backpressure
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= 9'h000;
      end else if (pop) begin
         out_valid <= 1'b1;
         result    <= restored;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef SIG_UNRECT_SAT_FLAG_EN
   logic sat_hit;

   assign sat_hit = !sgn && mag_data[8];

   // sticky record of any clamped sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_err <= 1'b0;
      end else if (pop && sat_hit) begin
         sat_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_sig_unrect.sv
// tb_sig_unrect: directed and random checks of sig_unrect against a queue model.
// Checks sat_err only when SIG_UNRECT_SAT_FLAG_EN is defined.
module tb_sig_unrect;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       raw_valid;
   logic [8:0] raw_data;
   logic       raw_ready;
   logic       mag_valid;
   logic [8:0] mag_data;
   logic       mag_ready;
   logic       out_valid;
   logic       out_ready;
   logic [8:0] result;
`ifdef SIG_UNRECT_SAT_FLAG_EN
   logic       sat_err;
`endif

   int checks = 0;
   int errors = 0;

   bit         q[$];
   bit         m_ov;
   logic [8:0] m_res;
   bit         m_sat;

   always #5 clk = ~clk;

   sig_unrect #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw_valid (raw_valid),
      .raw_data  (raw_data),
      .raw_ready (raw_ready),
      .mag_valid (mag_valid),
      .mag_data  (mag_data),
      .mag_ready (mag_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
`ifdef SIG_UNRECT_SAT_FLAG_EN
      ,
      .sat_err   (sat_err)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic logic [8:0] restore(input bit s, input int m);
      if (s) return 9'((512 - m) % 512);
      if (m >= 256) return 9'd255;
      return 9'(m);
   endfunction

   task automatic step(input bit rv, input logic [8:0] rd, input bit mv,
                       input logic [8:0] md, input bit ordy);
      bit er, em, s;
      @(negedge clk);
      raw_valid = rv;
      raw_data  = rd;
      mag_valid = mv;
      mag_data  = md;
      out_ready = ordy;
      #1;
      er = (q.size() != DEPTH);
      em = (q.size() != 0) && (!m_ov || ordy);
      chk("raw_ready", raw_ready, er);
      chk("mag_ready", mag_ready, em);
      if (mv && em) begin
         s     = q.pop_front();
         m_ov  = 1'b1;
         m_res = restore(s, int'(md));
         if (!s && md >= 9'd256) m_sat = 1'b1;
      end else if (ordy) begin
         m_ov = 1'b0;
      end
      if (rv && er) q.push_back(rd[8]);
      @(posedge clk);
      #1;
      chk("out_valid", out_valid, m_ov);
      if (m_ov) chk("result", result, m_res);
`ifdef SIG_UNRECT_SAT_FLAG_EN
      chk("sat_err", sat_err, m_sat);
`endif
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      q.delete();
      m_ov  = 1'b0;
      m_sat = 1'b0;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_result", result, 9'h000);
      chk("rst_raw_ready", raw_ready, 1'b1);
      chk("rst_mag_ready", mag_ready, 1'b0);
`ifdef SIG_UNRECT_SAT_FLAG_EN
      chk("rst_sat_err", sat_err, 1'b0);
`endif
      raw_valid = 1'b0;
      mag_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b1;
      raw_valid = 1'b0;
      raw_data  = '0;
      mag_valid = 1'b0;
      mag_data  = '0;
      out_ready = 1'b1;
      m_ov      = 1'b0;
      m_res     = '0;
      m_sat     = 1'b0;
      do_reset();

      // single negative sample
      step(1, 9'h1F6, 0, 9'h000, 1);
      step(0, 9'h000, 1, 9'h00A, 1);
      chk("neg10", result, 9'h1F6);
      step(0, 9'h000, 0, 9'h000, 1);

      // back-to-back mixed signs
      step(1, 9'h005, 0, 9'h000, 1);
      step(1, 9'h1F9, 0, 9'h000, 1);
      step(1, 9'h000, 0, 9'h000, 1);
      step(1, 9'h100, 0, 9'h000, 1);
      step(0, 9'h000, 1, 9'd5, 1);
      chk("seq0", result, 9'd5);
      step(0, 9'h000, 1, 9'd7, 1);
      chk("seq1", result, 9'h1F9);
      step(0, 9'h000, 1, 9'd0, 1);
      chk("seq2", result, 9'd0);
      step(0, 9'h000, 1, 9'd256, 1);
      chk("seq3", result, 9'h100);
      step(0, 9'h000, 0, 9'h000, 1);

      // fill to full, then push and pop together
      for (int i = 0; i < DEPTH; i++) step(1, 9'(i * 37), 0, 9'h000, 1);
      chk("full_rr", raw_ready, 1'b0);
      step(1, 9'h1AA, 1, 9'h033, 1);
      step(1, 9'h0AA, 0, 9'h000, 1);
      for (int i = 0; i < DEPTH; i++) step(0, 9'h000, 1, 9'(i * 61), 1);
      step(0, 9'h000, 0, 9'h000, 1);

      // saturation of positive magnitude
      step(1, 9'h010, 0, 9'h000, 1);
      step(0, 9'h000, 1, 9'h150, 1);
      chk("sat", result, 9'h0FF);
      step(0, 9'h000, 0, 9'h000, 1);
      step(0, 9'h000, 0, 9'h000, 1);

      // backpressure holds result and fifo
      step(1, 9'h180, 0, 9'h000, 1);
      step(1, 9'h001, 0, 9'h000, 1);
      step(0, 9'h000, 1, 9'h020, 0);
      for (int i = 0; i < 5; i++) step(0, 9'h000, 1, 9'h044, 0);
      chk("hold", result, 9'h1E0);
      step(0, 9'h000, 1, 9'h044, 1);
      step(0, 9'h000, 0, 9'h000, 1);

      // reset mid-stream with pending result
      step(1, 9'h100, 0, 9'h000, 1);
      step(1, 9'h000, 0, 9'h000, 1);
      step(1, 9'h100, 0, 9'h000, 1);
      step(1, 9'h100, 0, 9'h000, 1);
      step(0, 9'h000, 1, 9'h003, 0);
      do_reset();
      step(0, 9'h000, 1, 9'h003, 1);

      // random traffic
      for (int i = 0; i < 2000; i++) begin
         if (i == 1000) do_reset();
         step(bit'($urandom_range(0, 1)), 9'($urandom),
              bit'($urandom_range(0, 1)), 9'($urandom),
              $urandom_range(0, 3) != 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
